// File: rtl/lcd_pkg.sv
// Shared opcode constants and scheduler state encoding for the LCD command path.
package lcd_pkg;

    localparam logic [3:0] OP_W    = 4'h0;
    localparam logic [3:0] OP_MY   = 4'hB;
    localparam logic [3:0] OP_LAST = 4'hB;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FIN       = 3'd4
    } sched_state_e;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op > OP_LAST);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO with full/empty flags and a look-ahead full flag
// so the owner can register its ready output without a combinational path.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             full_next_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == '0);
    assign do_push_s   = push_i && !full_o;
    assign do_pop_s    = pop_i && !empty_o;
    assign head_o      = mem_q[rd_ptr_q];
    assign full_next_o = (count_d == FULL_CNT);

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage array; contents are only meaningful while the count covers them.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-requester round-robin command scheduler feeding the LCD engine handshake;
// write-back (0x0) ends the session until reset.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_W      = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] req0_cmd,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CMD_W-1:0] req1_cmd,
    input  logic             req1_valid,
    output logic             req1_ready,
    output logic [CMD_W-1:0] lcd_cmd,
    output logic             lcd_cmd_valid,
    input  logic             lcd_busy,
    input  logic             lcd_done,
    output logic             illegal_cmd,
    output logic [CNT_W-1:0] issue_cnt,
    output logic             sched_done
);
    sched_state_e     state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             valid_q, valid_d, illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, rdy0_q, rdy0_d, rdy1_q, rdy1_d;

    logic             push0_s, push1_s, pop0_s, pop1_s;
    logic             empty0_s, empty1_s, full0_s, full1_s, fnext0_s, fnext1_s;
    logic [CMD_W-1:0] head0_s, head1_s, head_s;
    logic             have_s, sel_s, head_bad_s, accept_s;

    assign push0_s = req0_valid && rdy0_q;
    assign push1_s = req1_valid && rdy1_q;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo0 (
        .clk(clk), .reset(reset), .push_i(push0_s), .din_i(req0_cmd), .pop_i(pop0_s),
        .head_o(head0_s), .empty_o(empty0_s), .full_o(full0_s), .full_next_o(fnext0_s)
    );

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo1 (
        .clk(clk), .reset(reset), .push_i(push1_s), .din_i(req1_cmd), .pop_i(pop1_s),
        .head_o(head1_s), .empty_o(empty1_s), .full_o(full1_s), .full_next_o(fnext1_s)
    );

    // Pointer only matters when both FIFOs hold work.
    assign have_s     = !empty0_s || !empty1_s;
    assign sel_s      = (!empty0_s && !empty1_s) ? ptr_q : !empty1_s;
    assign head_s     = sel_s ? head1_s : head0_s;
    assign head_bad_s = op_is_illegal(4'(head_s));

    // Arbitration, FSM next state and issue/drop decisions.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cmd_d     = cmd_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        pop0_s    = 1'b0;
        pop1_s    = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (have_s && head_bad_s) begin
                    pop0_s    = !sel_s;
                    pop1_s    = sel_s;
                    illegal_d = 1'b1;
                    ptr_d     = !sel_s;
                end else if (have_s && !lcd_busy) begin
                    pop0_s  = !sel_s;
                    pop1_s  = sel_s;
                    cmd_d   = head_s;
                    valid_d = 1'b1;
                    ptr_d   = !sel_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_ISSUE:     state_d = (cmd_q == CMD_W'(OP_W)) ? ST_WAIT_DONE : ST_WAIT;
            ST_WAIT:      state_d = ST_ARB;
            ST_WAIT_DONE: state_d = lcd_done ? ST_FIN : ST_WAIT_DONE;
            ST_FIN:       state_d = ST_FIN;
            default:      state_d = ST_ARB;
        endcase
    end

    // Ready is registered from next state and next fullness so it is clean after reset.
    always_comb begin
        accept_s = (state_d == ST_ARB) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        rdy0_d   = accept_s && !fnext0_s;
        rdy1_d   = accept_s && !fnext1_s;
        done_d   = done_q || (state_d == ST_FIN);
        if ((state_q == ST_ISSUE) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_ARB;
            ptr_q     <= 1'b0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rdy0_q    <= rdy0_d;
            rdy1_q    <= rdy1_d;
        end
    end

    assign req0_ready    = rdy0_q;
    assign req1_ready    = rdy1_q;
    assign lcd_cmd       = cmd_q;
    assign lcd_cmd_valid = valid_q;
    assign illegal_cmd   = illegal_q;
    assign issue_cnt     = cnt_q;
    assign sched_done    = done_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: busy hold, round-robin order, illegal drop,
// full FIFO, terminal write-back and reset during ISSUE.
module tb_lcd_cmd_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req0_cmd, req1_cmd, lcd_cmd;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic       lcd_cmd_valid, lcd_busy, lcd_done, illegal_cmd, sched_done;
    logic [7:0] issue_cnt;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         illegal_seen = 0;
    int         back2back = 0;
    int         rdy_hi;
    logic       prev_valid = 1'b0;
    logic [3:0] issued_q[$];
    int         issue_cyc_q[$];

    always #5 clk = ~clk;

    lcd_cmd_sched dut (
        .clk(clk), .reset(reset),
        .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .illegal_cmd(illegal_cmd), .issue_cnt(issue_cnt), .sched_done(sched_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every issued opcode, illegal pulse and any back-to-back valid.
    always @(negedge clk) begin
        if (lcd_cmd_valid === 1'b1) begin
            issued_q.push_back(lcd_cmd);
            issue_cyc_q.push_back(cyc);
            if (prev_valid) back2back++;
        end
        if (illegal_cmd === 1'b1) illegal_seen++;
        prev_valid = (lcd_cmd_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic v0, input logic [3:0] c0, input logic v1, input logic [3:0] c1);
        req0_valid = v0; req0_cmd = c0;
        req1_valid = v1; req1_cmd = c1;
        step(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        issued_q.delete();
        issue_cyc_q.delete();
        illegal_seen = 0;
    endtask

    function automatic logic [31:0] issued_at(input int i);
        if (i < issued_q.size()) return 32'(issued_q[i]);
        return 32'hDEAD;
    endfunction

    initial begin
        reset = 1'b0; lcd_busy = 1'b1; lcd_done = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_cmd = 4'h0; req1_cmd = 4'h0;
        step(2);
        check("rst_valid", 32'(lcd_cmd_valid), 32'd0);
        check("rst_cmd", 32'(lcd_cmd), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_illegal", 32'(illegal_cmd), 32'd0);
        check("rst_cnt", 32'(issue_cnt), 32'd0);
        check("rst_done", 32'(sched_done), 32'd0);
        reset = 1'b1;
        step(1);
        check("post_rst_ready0", 32'(req0_ready), 32'd1);

        // Busy holds everything in the FIFO.
        push(1'b1, 4'h1, 1'b0, 4'h0);
        push(1'b1, 4'h4, 1'b0, 4'h0);
        step(70);
        check("t1_none_while_busy", 32'(issued_q.size()), 32'd0);
        check("t1_cnt_busy", 32'(issue_cnt), 32'd0);
        lcd_busy = 1'b0;
        step(10);
        check("t1_count", 32'(issued_q.size()), 32'd2);
        check("t1_first", issued_at(0), 32'h1);
        check("t1_second", issued_at(1), 32'h4);
        if (issue_cyc_q.size() == 2) check("t1_spacing", 32'(issue_cyc_q[1] - issue_cyc_q[0]), 32'd3);
        else check("t1_spacing_missing", 32'(issue_cyc_q.size()), 32'd2);
        check("t1_cnt", 32'(issue_cnt), 32'd2);

        // Round-robin between two loaded FIFOs.
        lcd_busy = 1'b1;
        do_reset();
        push(1'b1, 4'h5, 1'b1, 4'h9);
        push(1'b1, 4'h6, 1'b1, 4'hA);
        step(2);
        lcd_busy = 1'b0;
        step(16);
        check("t2_count", 32'(issued_q.size()), 32'd4);
        check("t2_o0", issued_at(0), 32'h5);
        check("t2_o1", issued_at(1), 32'h9);
        check("t2_o2", issued_at(2), 32'h6);
        check("t2_o3", issued_at(3), 32'hA);
        check("t2_cnt", 32'(issue_cnt), 32'd4);

        // Illegal opcode dropped with a single pulse.
        do_reset();
        push(1'b0, 4'h0, 1'b1, 4'hD);
        push(1'b0, 4'h0, 1'b1, 4'h7);
        step(8);
        check("t3_illegal_pulses", 32'(illegal_seen), 32'd1);
        check("t3_count", 32'(issued_q.size()), 32'd1);
        check("t3_cmd", issued_at(0), 32'h7);
        check("t3_cnt", 32'(issue_cnt), 32'd1);

        // Full FIFO: push lost, ready returns right after first pop.
        lcd_busy = 1'b1;
        do_reset();
        push(1'b1, 4'h1, 1'b0, 4'h0);
        push(1'b1, 4'h2, 1'b0, 4'h0);
        push(1'b1, 4'h3, 1'b0, 4'h0);
        push(1'b1, 4'h4, 1'b0, 4'h0);
        check("t4_full_ready", 32'(req0_ready), 32'd0);
        push(1'b1, 4'h8, 1'b0, 4'h0);
        check("t4_still_full", 32'(req0_ready), 32'd0);
        lcd_busy = 1'b0;
        step(1);
        check("t4_ready_after_pop", 32'(req0_ready), 32'd1);
        check("t4_issue_valid", 32'(lcd_cmd_valid), 32'd1);
        step(14);
        check("t4_count", 32'(issued_q.size()), 32'd4);
        check("t4_o0", issued_at(0), 32'h1);
        check("t4_o3", issued_at(3), 32'h4);
        check("t4_cnt", 32'(issue_cnt), 32'd4);

        // Terminal write-back; req1 leftovers never issued.
        lcd_busy = 1'b1;
        do_reset();
        push(1'b1, 4'h0, 1'b1, 4'h3);
        push(1'b0, 4'h0, 1'b1, 4'h2);
        lcd_busy = 1'b0;
        step(1);
        check("t5_wb_valid", 32'(lcd_cmd_valid), 32'd1);
        check("t5_wb_cmd", 32'(lcd_cmd), 32'h0);
        step(1);
        rdy_hi = 0;
        repeat (64) begin
            if (req0_ready || req1_ready) rdy_hi++;
            step(1);
        end
        check("t5_ready_low", 32'(rdy_hi), 32'd0);
        check("t5_not_done_yet", 32'(sched_done), 32'd0);
        lcd_done = 1'b1;
        step(1);
        lcd_done = 1'b0;
        check("t5_done", 32'(sched_done), 32'd1);
        step(10);
        check("t5_done_sticky", 32'(sched_done), 32'd1);
        check("t5_count", 32'(issued_q.size()), 32'd1);
        check("t5_cnt", 32'(issue_cnt), 32'd1);
        check("t5_ready1_fin", 32'(req1_ready), 32'd0);

        // Reset during ISSUE.
        do_reset();
        push(1'b1, 4'h5, 1'b1, 4'h6);
        step(1);
        check("t6_in_issue", 32'(lcd_cmd_valid), 32'd1);
        reset = 1'b0;
        step(1);
        check("t6_valid", 32'(lcd_cmd_valid), 32'd0);
        check("t6_cmd", 32'(lcd_cmd), 32'd0);
        check("t6_cnt", 32'(issue_cnt), 32'd0);
        check("t6_done", 32'(sched_done), 32'd0);
        check("t6_ready0", 32'(req0_ready), 32'd0);
        reset = 1'b1;
        step(10);
        check("t6_fifos_empty", 32'(issued_q.size()), 32'd1);
        check("t6_cnt_after", 32'(issue_cnt), 32'd0);
        check("t6_ready_back", 32'(req0_ready), 32'd1);

        check("no_back_to_back_valid", 32'(back2back), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
